// File: rtl/madd_eval_pkg.sv
// Shared definitions for the multiply-add error evaluator: widths, FSM state codes and the
// golden model of the datapath under evaluation.
package madd_eval_pkg;

  localparam int unsigned OpW  = 6;
  localparam int unsigned ResW = 12;

  typedef logic [1:0] madd_state_t;

  localparam madd_state_t StIdle  = 2'd0;
  localparam madd_state_t StRun   = 2'd1;
  localparam madd_state_t StDrain = 2'd2;
  localparam madd_state_t StDone  = 2'd3;

  // a*b + c is at most 63*63+63 = 4032, so ResW bits always hold it exactly.
  function automatic logic [ResW-1:0] exact_madd(input logic [OpW-1:0] a,
                                                  input logic [OpW-1:0] b,
                                                  input logic [OpW-1:0] c);
    return ResW'(a) * ResW'(b) + ResW'(c);
  endfunction

endpackage

// File: rtl/madd_err_metric.sv
// Combinational error metrics for one result: absolute difference and Hamming distance
// between the result under evaluation and the exact result.
module madd_err_metric
  import madd_eval_pkg::*;
(
  input  logic [ResW-1:0] res_i,
  input  logic [ResW-1:0] exact_i,
  output logic [ResW-1:0] abs_diff_o,
  output logic [3:0]      ham_o
);

  logic signed [ResW:0] diff;
  logic [ResW-1:0]      flips;

  // Signed subtract one bit wider than the operands, then take the magnitude.
  always_comb begin
    diff       = $signed({1'b0, res_i}) - $signed({1'b0, exact_i});
    abs_diff_o = diff[ResW] ? ResW'(-diff) : diff[ResW-1:0];
    flips      = res_i ^ exact_i;
    ham_o      = '0;
    for (int i = 0; i < ResW; i++) begin
      ham_o = ham_o + {3'b000, flips[i]};
    end
  end

endmodule

// File: rtl/madd_err_accum.sv
// Error accumulator for a multiply-add datapath under test. Accepts N_SAMPLES operand/result
// pairs per run, recomputes the exact result and accumulates mismatch count, saturating
// absolute-error sum, maximum absolute error and maximum Hamming distance.
module madd_err_accum
  import madd_eval_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 262144,
  parameter int unsigned CNT_W     = 19,
  parameter int unsigned SUM_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [OpW-1:0]   s_a,
  input  logic [OpW-1:0]   s_b,
  input  logic [OpW-1:0]   s_c,
  input  logic [ResW-1:0]  s_res,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] err_sum,
  output logic [ResW-1:0]  err_max,
  output logic [3:0]       ham_max
);

  madd_state_t state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

  logic accept, run_start, last_accept;

  // Stage 1: exact result and captured result.
  logic            v1_q;
  logic [ResW-1:0] exact1_q, res1_q;
  // Stage 2: per-sample error metrics.
  logic            v2_q;
  logic [ResW-1:0] d2_q, d_c;
  logic [3:0]      h2_q, h_c;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0] err_sum_q, err_sum_d;
  logic [SUM_W:0]   sum_ext;
  logic [ResW-1:0]  err_max_q, err_max_d;
  logic [3:0]       ham_max_q, ham_max_d;

  assign s_ready     = (state_q == StRun);
  assign busy        = (state_q == StRun) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign accept      = s_valid && s_ready;
  // start is only honoured when no run is in flight.
  assign run_start   = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_accept = accept && (acc_cnt_q == CNT_W'(N_SAMPLES - 1));

  assign err_cnt = err_cnt_q;
  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
  assign ham_max = ham_max_q;

  madd_err_metric u_metric (
    .res_i      (res1_q),
    .exact_i    (exact1_q),
    .abs_diff_o (d_c),
    .ham_o      (h_c)
  );

  // Run sequencing: RUN until the last accept, DRAIN until the pipeline is empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (last_accept) state_d = StDrain;
      StDrain:        if (!v1_q && !v2_q) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Accept counter, cleared at the start of every run.
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (run_start) begin
      acc_cnt_d = '0;
    end else if (accept) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
  end

  // Metric accumulation from stage 2; the sum clamps instead of wrapping.
  always_comb begin
    sum_ext   = {1'b0, err_sum_q} + (SUM_W + 1)'(d2_q);
    err_cnt_d = err_cnt_q;
    err_sum_d = err_sum_q;
    err_max_d = err_max_q;
    ham_max_d = ham_max_q;
    if (run_start) begin
      err_cnt_d = '0;
      err_sum_d = '0;
      err_max_d = '0;
      ham_max_d = '0;
    end else if (v2_q) begin
      err_cnt_d = err_cnt_q + CNT_W'(d2_q != '0);
      err_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      err_max_d = (d2_q > err_max_q) ? d2_q : err_max_q;
      ham_max_d = (h2_q > ham_max_q) ? h2_q : ham_max_q;
    end
  end

  // Control state and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_cnt_q <= '0;
      err_cnt_q <= '0;
      err_sum_q <= '0;
      err_max_q <= '0;
      ham_max_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_sum_q <= err_sum_d;
      err_max_q <= err_max_d;
      ham_max_q <= ham_max_d;
    end
  end

  // Two-stage evaluation pipeline; it never stalls, data only moves with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      exact1_q <= '0;
      res1_q   <= '0;
      v2_q     <= 1'b0;
      d2_q     <= '0;
      h2_q     <= '0;
    end else begin
      v1_q <= accept;
      v2_q <= v1_q;
      if (accept) begin
        exact1_q <= exact_madd(s_a, s_b, s_c);
        res1_q   <= s_res;
      end
      if (v1_q) begin
        d2_q <= d_c;
        h2_q <= h_c;
      end
    end
  end

endmodule

// File: tb/tb_madd_err_accum.sv
// Scoreboard bench for madd_err_accum: the driver runs a behavioural model per accepted
// sample and queues the expected running metrics; the monitor compares them when each sample
// matures in the outputs, and compares final metrics when done rises.
module tb_madd_err_accum;

  localparam int unsigned N       = 8;
  localparam int unsigned CW      = 19;
  localparam int unsigned SW      = 13;
  localparam longint      SUM_CAP = (longint'(1) << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [5:0]    s_a = '0, s_b = '0, s_c = '0;
  logic [11:0]   s_res = '0;
  logic          busy, done;
  logic [CW-1:0] err_cnt;
  logic [SW-1:0] err_sum;
  logic [11:0]   err_max;
  logic [3:0]    ham_max;

  madd_err_accum #(.N_SAMPLES(N), .CNT_W(CW), .SUM_W(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .s_c     (s_c),
    .s_res   (s_res),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .err_sum (err_sum),
    .err_max (err_max),
    .ham_max (ham_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint cnt;
    longint sum;
    longint emax;
    longint hmax;
  } metrics_t;

  metrics_t q_live[$];
  metrics_t q_final[$];
  metrics_t mdl;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: error of one sample by plain integer arithmetic.
  task automatic model_step(input int a, input int b, input int c, input int res);
    int ex, d, h;
    ex = a * b + c;
    d  = (res > ex) ? res - ex : ex - res;
    h  = $countones(res ^ ex);
    if (d != 0) mdl.cnt++;
    mdl.sum = (mdl.sum + d > SUM_CAP) ? SUM_CAP : mdl.sum + d;
    if (d > mdl.emax) mdl.emax = d;
    if (h > mdl.hmax) mdl.hmax = h;
  endtask

  // mode 0 clean, 1 random errors, 2 directed table, 3 maximal error.
  task automatic load_sample(input int mode, input int idx);
    int a, b, c, ex;
    a = $urandom_range(0, 63);
    b = $urandom_range(0, 63);
    c = $urandom_range(0, 63);
    ex = a * b + c;
    s_a = 6'(a); s_b = 6'(b); s_c = 6'(c); s_res = 12'(ex);
    case (mode)
      1: if ($urandom_range(0, 2) != 0) s_res = 12'($urandom_range(0, 4095));
      2: case (idx)
           0: begin s_a = 6'd63; s_b = 6'd63; s_c = 6'd63; s_res = 12'd4032; end
           1: begin s_a = 6'd1;  s_b = 6'd1;  s_c = 6'd0;  s_res = 12'd0;    end
           2: begin s_a = 6'd2;  s_b = 6'd3;  s_c = 6'd4;  s_res = 12'd0;    end
           3: begin s_a = 6'd0;  s_b = 6'd0;  s_c = 6'd0;  s_res = 12'd4095; end
           default: ;
         endcase
      3: begin s_a = 6'd0; s_b = 6'd0; s_c = 6'd0; s_res = 12'd4095; end
      default: ;
    endcase
  endtask

  // vmode 0 always valid, 1 valid toggling, 2 random valid.
  task automatic do_run(input int mode, input int vmode, input int start_at, input int rst_at);
    int  acc;
    int  idle;
    bit  fire;
    mdl  = '{0, 0, 0, 0};
    acc  = 0;
    idle = 0;
    @(posedge clk); #1;
    start = 1'b1;
    load_sample(mode, 0);
    s_valid = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (acc < N) begin
      @(negedge clk);
      fire = s_valid && s_ready;
      if (fire) begin
        model_step(int'(s_a), int'(s_b), int'(s_c), int'(s_res));
        q_live.push_back(mdl);
        acc++;
        idle = 0;
      end else begin
        idle++;
        if (idle > 50) begin
          check("accept_timeout", acc, N);
          start = 1'b0;
          s_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (fire) begin
        load_sample(mode, acc);
        s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (acc == start_at) start = 1'b1;
        if (acc == rst_at) begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_err_cnt", err_cnt, 0);
          check("rst_err_sum", err_sum, 0);
          check("rst_err_max", err_max, 0);
          check("rst_ham_max", ham_max, 0);
          check("rst_ready_busy_done", {s_ready, busy, done}, 0);
          q_live.delete();
          q_final.delete();
          s_valid = 1'b0;
          start = 1'b0;
          @(posedge clk); #3;
          rst_n = 1'b1;
          return;
        end
      end else if (!s_valid) begin
        s_valid = (vmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    q_final.push_back(mdl);
    // Offer one more sample to prove it is refused.
    s_valid = 1'b1;
    @(negedge clk);
    check("s_ready_after_last", s_ready, 0);
    check("busy_in_drain", busy, 1);
    @(negedge clk);
    @(negedge clk);
    check("done_not_early", done, 0);
    @(negedge clk);
    check("done_rise", done, 1);
    check("busy_when_done", busy, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("held_err_cnt", err_cnt, mdl.cnt);
    check("held_err_sum", err_sum, mdl.sum);
    check("held_done", done, 1);
  endtask

  // Monitor: a sample seen accepted at one falling edge is checked three falling edges later.
  logic [2:0] fire_hist = '0;
  int         fire_cnt = 0;
  logic       done_prev = 1'b0;
  metrics_t   e;

  always @(negedge clk) begin
    if (!rst_n) begin
      fire_hist = '0;
      fire_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (fire_hist[2]) begin
        check("live_queue_nonempty", q_live.size() != 0, 1);
        if (q_live.size() != 0) begin
          e = q_live.pop_front();
          check("live_err_cnt", err_cnt, e.cnt);
          check("live_err_sum", err_sum, e.sum);
          check("live_err_max", err_max, e.emax);
          check("live_ham_max", ham_max, e.hmax);
        end
      end
      if (done && !done_prev) begin
        check("final_queue_nonempty", q_final.size() != 0, 1);
        if (q_final.size() != 0) begin
          e = q_final.pop_front();
          check("final_err_cnt", err_cnt, e.cnt);
          check("final_err_sum", err_sum, e.sum);
          check("final_err_max", err_max, e.emax);
          check("final_ham_max", ham_max, e.hmax);
          check("accept_count", fire_cnt, N);
        end
        fire_cnt = 0;
      end
      done_prev = done;
      fire_hist = {fire_hist[1:0], s_valid && s_ready};
      if (s_valid && s_ready) fire_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_metrics", {err_cnt, err_sum, err_max, ham_max}, 0);
    check("reset_ready_busy_done", {s_ready, busy, done}, 0);
    rst_n = 1'b1;
    s_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_not_ready", s_ready, 0);
    check("idle_not_busy", busy, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;

    do_run(0, 0, -1, -1);   // clean source
    do_run(2, 0, -1, -1);   // directed errors
    do_run(1, 1, -1, -1);   // valid toggling
    do_run(1, 0, 3, -1);    // start pulsed mid-run
    do_run(1, 2, -1, 5);    // reset mid-run
    do_run(0, 2, -1, -1);   // clean run after reset
    do_run(3, 0, -1, -1);   // saturating sum
    for (int r = 0; r < 6; r++) begin
      do_run(1, 2, -1, -1);
    end

    repeat (5) @(negedge clk);
    check("live_queue_drained", q_live.size(), 0);
    check("final_queue_drained", q_final.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
